// File: rtl/loteria_sorteio.sv
// loteria_sorteio
// Draws five decimal digits from an internal 16-bit LFSR and then transmits
// them on the lottery entry protocol (num / insert / finish). Rejection
// sampling discards nibbles 10..15, so every stored digit is 0..9.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   start      begin a draw, only honoured in IDLE or DONE
//   num        digit being transmitted during SEND/GAP, 0 otherwise
//   insert     one-cycle strobe, num is valid
//   finish     one-cycle strobe after the fifth digit
//   busy       high in DRAW, SEND, GAP and FIN
//   LEDR       thermometer code of the state index
//   HEX0..HEX4 drawn digits d4..d0 (active-low segments, blank until drawn)
//   HEX5       constant dash
module loteria_sorteio #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          GAP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] num,
    output logic       insert,
    output logic       finish,
    output logic       busy,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DRAW = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  GAP_RELOAD = 4'(GAP - 1);

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [2:0]  r_k;
    logic [3:0]  r_gapCnt;
    logic [3:0]  r_digit [0:4];
    logic [4:0]  r_valid;

    logic        w_fb;
    logic [3:0]  w_nibble;
    logic        w_accept;

    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_nibble = r_lfsr[3:0];
    assign w_accept = (w_nibble <= 4'd9);

    // Active-low 7-segment encoding (gfedcba) for decimal digits.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Control FSM. The LFSR advances on every DRAW cycle, accepted or
    // rejected, and is only reloaded by reset so successive draws differ.
    // r_k indexes the digit being drawn in DRAW and the digit being sent in
    // SEND/GAP; it stays at 4 through FIN and DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_lfsr   <= SEED_EFF;
            r_k      <= 3'd0;
            r_gapCnt <= 4'd0;
            r_valid  <= 5'b00000;
            for (int i = 0; i < 5; i++) begin
                r_digit[i] <= 4'd0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_valid <= 5'b00000;
                        r_k     <= 3'd0;
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    r_lfsr <= {r_lfsr[14:0], w_fb};
                    if (w_accept) begin
                        r_digit[r_k] <= w_nibble;
                        r_valid[r_k] <= 1'b1;
                        if (r_k == 3'd4) begin
                            r_k     <= 3'd0;
                            r_state <= S_SEND;
                        end else begin
                            r_k <= r_k + 3'd1;
                        end
                    end
                end
                S_SEND: begin
                    r_gapCnt <= GAP_RELOAD;
                    r_state  <= S_GAP;
                end
                S_GAP: begin
                    if (r_gapCnt != 4'd0) begin
                        r_gapCnt <= r_gapCnt - 4'd1;
                    end else if (r_k == 3'd4) begin
                        r_state <= S_FIN;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_state <= S_SEND;
                    end
                end
                S_FIN: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Protocol outputs and board indicators, all decoded from registered state.
    always_comb begin
        num    = 4'd0;
        insert = 1'b0;
        finish = 1'b0;
        busy   = 1'b0;
        LEDR   = 10'h000;
        case (r_state)
            S_DRAW: begin
                busy = 1'b1;
                LEDR = 10'h001;
            end
            S_SEND: begin
                busy   = 1'b1;
                insert = 1'b1;
                num    = r_digit[r_k];
                LEDR   = 10'h003;
            end
            S_GAP: begin
                busy = 1'b1;
                num  = r_digit[r_k];
                LEDR = 10'h007;
            end
            S_FIN: begin
                busy   = 1'b1;
                finish = 1'b1;
                LEDR   = 10'h00F;
            end
            S_DONE: begin
                LEDR = 10'h01F;
            end
            default: begin
                LEDR = 10'h000;
            end
        endcase
    end

    // HEX4 shows the first digit drawn and HEX0 the last; a digit slot stays
    // blank until its valid flag is set during the current draw.
    always_comb begin
        HEX0 = r_valid[4] ? seg7(r_digit[4]) : 7'b1111111;
        HEX1 = r_valid[3] ? seg7(r_digit[3]) : 7'b1111111;
        HEX2 = r_valid[2] ? seg7(r_digit[2]) : 7'b1111111;
        HEX3 = r_valid[1] ? seg7(r_digit[1]) : 7'b1111111;
        HEX4 = r_valid[0] ? seg7(r_digit[0]) : 7'b1111111;
        HEX5 = 7'b0111111;
    end

endmodule

// File: tb/tb_loteria_sorteio.sv
// tb_loteria_sorteio
// Self-checking bench for loteria_sorteio. Three instances are used:
// inst0 SEED=1, inst1 SEED=F, inst2 SEED=0 (must behave like SEED=1).
// Digits expected from inst0 are pushed to a scoreboard queue when a draw
// is started and popped by the protocol monitor on every insert pulse.
module tb_loteria_sorteio;

    localparam int GAP = 2;
    localparam int PER = GAP + 1;

    logic       clk;
    logic       reset;
    logic       startA [3];
    logic [3:0] numA   [3];
    logic       insA   [3];
    logic       finA   [3];
    logic       busyA  [3];
    logic [9:0] ledrA  [3];
    logic [6:0] hexA   [3][6];

    int          checks;
    int          failures;
    int          cyc;
    logic [15:0] mLfsr [3];
    logic [3:0]  expQ [$];

    loteria_sorteio #(.SEED(16'h0001), .GAP(GAP)) dut0 (
        .clk(clk), .reset(reset), .start(startA[0]), .num(numA[0]),
        .insert(insA[0]), .finish(finA[0]), .busy(busyA[0]), .LEDR(ledrA[0]),
        .HEX0(hexA[0][0]), .HEX1(hexA[0][1]), .HEX2(hexA[0][2]),
        .HEX3(hexA[0][3]), .HEX4(hexA[0][4]), .HEX5(hexA[0][5])
    );

    loteria_sorteio #(.SEED(16'h000F), .GAP(GAP)) dut1 (
        .clk(clk), .reset(reset), .start(startA[1]), .num(numA[1]),
        .insert(insA[1]), .finish(finA[1]), .busy(busyA[1]), .LEDR(ledrA[1]),
        .HEX0(hexA[1][0]), .HEX1(hexA[1][1]), .HEX2(hexA[1][2]),
        .HEX3(hexA[1][3]), .HEX4(hexA[1][4]), .HEX5(hexA[1][5])
    );

    loteria_sorteio #(.SEED(16'h0000), .GAP(GAP)) dut2 (
        .clk(clk), .reset(reset), .start(startA[2]), .num(numA[2]),
        .insert(insA[2]), .finish(finA[2]), .busy(busyA[2]), .LEDR(ledrA[2]),
        .HEX0(hexA[2][0]), .HEX1(hexA[2][1]), .HEX2(hexA[2][2]),
        .HEX3(hexA[2][3]), .HEX4(hexA[2][4]), .HEX5(hexA[2][5])
    );

    // 10 ns clock and a free-running cycle counter for spacing checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] segRef(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        segRef = (d <= 4'd9) ? tbl[d] : 7'b1111111;
    endfunction

    // Reference draw: rejection sampling over the Fibonacci LFSR.
    task automatic modelDraw(input logic [15:0] lin, output logic [19:0] digs,
                             output logic [15:0] lout, output int nd);
        logic [15:0] l;
        int k;
        l = lin;
        k = 0;
        nd = 0;
        digs = 20'h0;
        while (k < 5 && nd < 200) begin
            nd++;
            if (l[3:0] <= 4'd9) begin
                digs[k*4 +: 4] = l[3:0];
                k++;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        lout = l;
    endtask

    // Protocol monitor on inst0: scoreboard digits, pulse spacing,
    // exactly five inserts before finish, no overlapping strobes.
    task automatic monitor();
        int insCount;
        int lastCyc;
        bit haveLast;
        logic [3:0] expNum;
        insCount = 0;
        lastCyc = 0;
        haveLast = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                expQ.delete();
                insCount = 0;
                haveLast = 0;
            end else begin
                checks++;
                if (insA[0] && finA[0]) begin
                    failures++;
                    $display("FAIL strobe_overlap cyc=%0d insert=%b finish=%b required not both", cyc, insA[0], finA[0]);
                end
                if (insA[0]) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        failures++;
                        $display("FAIL scoreboard_num cyc=%0d got=%0d but no digit expected", cyc, numA[0]);
                    end else begin
                        expNum = expQ.pop_front();
                        if (numA[0] !== expNum) begin
                            failures++;
                            $display("FAIL scoreboard_num cyc=%0d got=%0d exp=%0d", cyc, numA[0], expNum);
                        end
                    end
                    checks++;
                    if (!(numA[0] <= 4'd9)) begin
                        failures++;
                        $display("FAIL num_range cyc=%0d got=%0d exp<=9", cyc, numA[0]);
                    end
                    if (haveLast) begin
                        checks++;
                        if (cyc - lastCyc != PER) begin
                            failures++;
                            $display("FAIL insert_spacing cyc=%0d got=%0d exp=%0d", cyc, cyc - lastCyc, PER);
                        end
                    end
                    lastCyc = cyc;
                    haveLast = 1;
                    insCount++;
                end
                if (finA[0]) begin
                    checks++;
                    if (insCount != 5) begin
                        failures++;
                        $display("FAIL finish_count cyc=%0d got=%0d inserts exp=5", cyc, insCount);
                    end
                    checks++;
                    if (!haveLast || cyc - lastCyc != PER) begin
                        failures++;
                        $display("FAIL finish_spacing cyc=%0d got=%0d exp=%0d", cyc, cyc - lastCyc, PER);
                    end
                    insCount = 0;
                    haveLast = 0;
                end
            end
        end
    endtask

    // One draw on an instance, checked cycle by cycle against the timeline
    // derived from the reference draw. hold keeps start high; stopIns>0
    // returns one cycle after insert number stopIns.
    task automatic runDraw(input int which, input bit hold, input int stopIns,
                           output logic [19:0] digs);
        logic [15:0] lout;
        int nd, last, full, idx, off;
        logic [3:0] expNum;
        logic [9:0] expLedr;
        modelDraw(mLfsr[which], digs, lout, nd);
        mLfsr[which] = lout;
        if (which == 0) begin
            for (int i = 0; i < 5; i++) expQ.push_back(digs[i*4 +: 4]);
        end
        startA[which] = 1'b1;
        full = nd + 5 * PER + 2;
        last = (stopIns > 0) ? nd + 1 + (stopIns - 1) * PER + 1 : full;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && !hold) startA[which] = 1'b0;
            @(negedge clk);
            expNum = 4'd0;
            if (c <= nd) idx = 1;
            else if (c <= nd + 5 * PER) begin
                off = c - nd - 1;
                idx = (off % PER == 0) ? 2 : 3;
                expNum = digs[(off / PER)*4 +: 4];
            end else if (c == nd + 5 * PER + 1) idx = 4;
            else idx = 5;
            expLedr = 10'((1 << idx) - 1);
            checks++;
            if (ledrA[which] !== expLedr) begin
                failures++;
                $display("FAIL ledr inst%0d c=%0d got=%h exp=%h", which, c, ledrA[which], expLedr);
            end
            checks++;
            if (busyA[which] !== (idx >= 1 && idx <= 4)) begin
                failures++;
                $display("FAIL busy inst%0d c=%0d got=%b exp=%b", which, c, busyA[which], (idx >= 1 && idx <= 4));
            end
            checks++;
            if (insA[which] !== (idx == 2) || finA[which] !== (idx == 4)) begin
                failures++;
                $display("FAIL strobes inst%0d c=%0d got ins=%b fin=%b exp ins=%b fin=%b", which, c, insA[which], finA[which], idx == 2, idx == 4);
            end
            checks++;
            if (numA[which] !== expNum) begin
                failures++;
                $display("FAIL num inst%0d c=%0d got=%0d exp=%0d", which, c, numA[which], expNum);
            end
            if (c == 1) begin
                checks++;
                if ({hexA[which][4], hexA[which][3], hexA[which][2], hexA[which][1], hexA[which][0]} !== {5{7'b1111111}}) begin
                    failures++;
                    $display("FAIL hex_blank_at_draw inst%0d got=%h exp=all 7f", which,
                             {hexA[which][4], hexA[which][3], hexA[which][2], hexA[which][1], hexA[which][0]});
                end
            end
        end
        if (last == full) begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (hexA[which][4-i] !== segRef(digs[i*4 +: 4])) begin
                    failures++;
                    $display("FAIL hex_digit inst%0d HEX%0d got=%b exp=%b", which, 4 - i, hexA[which][4-i], segRef(digs[i*4 +: 4]));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busyA[i] !== 1'b0 || insA[i] !== 1'b0 || finA[i] !== 1'b0 || numA[i] !== 4'd0 || ledrA[i] !== 10'h000) begin
                failures++;
                $display("FAIL reset_outputs inst%0d got busy=%b ins=%b fin=%b num=%0d ledr=%h exp all 0", i, busyA[i], insA[i], finA[i], numA[i], ledrA[i]);
            end
            checks++;
            if ({hexA[i][4], hexA[i][3], hexA[i][2], hexA[i][1], hexA[i][0]} !== {5{7'b1111111}} || hexA[i][5] !== 7'b0111111) begin
                failures++;
                $display("FAIL reset_hex inst%0d got HEX5=%b HEX0=%b exp dash/blank", i, hexA[i][5], hexA[i][0]);
            end
        end
    endtask

    // Literal HEX4..HEX0 pattern 1,2,4,8,0 for a fresh SEED=1 stream.
    task automatic test_seed_one();
        logic [19:0] digs;
        logic [6:0] expHex [5];
        expHex = '{7'b1000000, 7'b0000000, 7'b0011001, 7'b0100100, 7'b1111001};
        runDraw(0, 1'b0, 0, digs);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (hexA[0][i] !== expHex[i]) begin
                failures++;
                $display("FAIL seed1_hex HEX%0d got=%b exp=%b", i, hexA[0][i], expHex[i]);
            end
        end
    endtask

    // SEED=F rejects F,E,C first: digits 8,0,0,0,0 after 8 DRAW cycles.
    task automatic test_seed_f();
        logic [19:0] digs;
        logic [6:0] expHex [5];
        expHex = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0000000};
        runDraw(1, 1'b0, 0, digs);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (hexA[1][i] !== expHex[i]) begin
                failures++;
                $display("FAIL seedF_hex HEX%0d got=%b exp=%b", i, hexA[1][i], expHex[i]);
            end
        end
    endtask

    task automatic test_seed_zero();
        logic [19:0] digs;
        logic [6:0] expHex [5];
        expHex = '{7'b1000000, 7'b0000000, 7'b0011001, 7'b0100100, 7'b1111001};
        runDraw(2, 1'b0, 0, digs);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (hexA[2][i] !== expHex[i]) begin
                failures++;
                $display("FAIL seed0_hex HEX%0d got=%b exp=%b", i, hexA[2][i], expHex[i]);
            end
        end
    endtask

    // Reset in GAP after the second insert, then replay from the seed.
    task automatic test_reset_mid_gap();
        logic [19:0] digs;
        logic [6:0] expHex [5];
        expHex = '{7'b1000000, 7'b0000000, 7'b0011001, 7'b0100100, 7'b1111001};
        runDraw(0, 1'b0, 2, digs);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mLfsr = '{16'h0001, 16'h000F, 16'h0001};
        @(negedge clk);
        checks++;
        if (busyA[0] !== 1'b0 || insA[0] !== 1'b0 || finA[0] !== 1'b0 || numA[0] !== 4'd0 || ledrA[0] !== 10'h000) begin
            failures++;
            $display("FAIL midgap_reset got busy=%b ins=%b fin=%b num=%0d ledr=%h exp all 0", busyA[0], insA[0], finA[0], numA[0], ledrA[0]);
        end
        checks++;
        if ({hexA[0][4], hexA[0][3], hexA[0][2], hexA[0][1], hexA[0][0]} !== {5{7'b1111111}} || hexA[0][5] !== 7'b0111111) begin
            failures++;
            $display("FAIL midgap_hex got HEX4=%b HEX5=%b exp blank/dash", hexA[0][4], hexA[0][5]);
        end
        runDraw(0, 1'b0, 0, digs);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (hexA[0][i] !== expHex[i]) begin
                failures++;
                $display("FAIL replay_hex HEX%0d got=%b exp=%b", i, hexA[0][i], expHex[i]);
            end
        end
    endtask

    // start held high: one draw, DONE re-triggers, LFSR continues.
    task automatic test_back_to_back();
        logic [19:0] digs;
        runDraw(0, 1'b1, 0, digs);
        runDraw(0, 1'b0, 0, digs);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        startA = '{1'b0, 1'b0, 1'b0};
        mLfsr = '{16'h0001, 16'h000F, 16'h0001};
        fork
            monitor();
        join_none
        test_reset();
        test_seed_one();
        test_seed_f();
        test_seed_zero();
        test_reset_mid_gap();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d digits pending exp=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
